// File: rtl/debug_hart_ctrl.sv
// debug_hart_ctrl: halts/resumes the core for debug and runs access-register abstract commands
module debug_hart_ctrl #(
  parameter logic [11:0] DPC_ADDR = 12'h7B1,
  parameter logic [15:0] GPR_BASE = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        exec,
  input  logic [31:0] command,
  input  logic [31:0] data0_in,
  input  logic [31:0] data1_in,
  output logic        halted,
  output logic        done,
  output logic        write,
  output logic        error,
  output logic        exception,
  output logic [31:0] data0_out,
  output logic        core_stall,
  input  logic        core_idle,
  input  logic [31:0] pc,
  output logic        core_resume,
  output logic [31:0] resume_pc,
  output logic [4:0]  gpr_addr,
  output logic        gpr_we,
  output logic [31:0] gpr_wdata,
  input  logic [31:0] gpr_rdata,
  output logic [11:0] csr_addr,
  output logic        csr_re,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_illegal
);
  typedef enum logic [2:0] {RUNNING, HALTING, HALTED, ACCESS, REPORT, RESUMING} state_t;
  state_t      state_q;
  logic [31:0] dpc_q, data0_q, rdata;
  logic [11:0] regno_q;
  logic [4:0]  idx_q;
  logic        err_q, xfer_q, wr_q, gpr_q, dpcr_q;
  logic [15:0] off_d;
  logic        gpr_d, csr_d, dpcr_d, err_d, act, csr_go, exc, rd_ok, unused_ok;
  assign off_d  = command[15:0] - GPR_BASE;
  assign gpr_d  = command[15:0] >= GPR_BASE && off_d < 16'd32;
  assign csr_d  = command[15:12] == 4'h0;
  assign dpcr_d = csr_d && !gpr_d && command[11:0] == DPC_ADDR;
  assign err_d  = command[31:24] != 8'h00 || command[22:20] != 3'd2 || command[19] || command[18] ||
                  (command[17] && !gpr_d && !csr_d);
  // strobes only in the single ACCESS cycle of a valid transfer; dpc never leaves this block
  assign act       = state_q == ACCESS && xfer_q && !err_q;
  assign csr_go    = act && !gpr_q && !dpcr_q;
  assign exc       = csr_go && csr_illegal;
  assign rd_ok     = act && !wr_q && !exc;
  assign rdata     = gpr_q ? gpr_rdata : dpcr_q ? dpc_q : csr_rdata;
  assign gpr_addr  = act && gpr_q ? idx_q : 5'd0;
  assign gpr_we    = act && gpr_q && wr_q;
  assign gpr_wdata = gpr_we ? data0_q : 32'd0;
  assign csr_addr  = csr_go ? regno_q : 12'd0;
  assign csr_re    = csr_go && !wr_q;
  assign csr_we    = csr_go && wr_q;
  assign csr_wdata = csr_we ? data0_q : 32'd0;
  assign resume_pc = dpc_q;
  assign unused_ok = ^{data1_in, command[23]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUNNING;
      halted      <= 1'b0;
      core_stall  <= 1'b0;
      core_resume <= 1'b0;
      done        <= 1'b0;
      write       <= 1'b0;
      error       <= 1'b0;
      exception   <= 1'b0;
      data0_out   <= 32'd0;
      dpc_q       <= 32'd0;
      data0_q     <= 32'd0;
      regno_q     <= 12'd0;
      idx_q       <= 5'd0;
      err_q       <= 1'b0;
      xfer_q      <= 1'b0;
      wr_q        <= 1'b0;
      gpr_q       <= 1'b0;
      dpcr_q      <= 1'b0;
    end else begin
      done        <= 1'b0;
      write       <= 1'b0;
      error       <= 1'b0;
      exception   <= 1'b0;
      core_resume <= 1'b0;
      case (state_q)
        RUNNING: if (halt_req) begin
          state_q    <= HALTING;
          core_stall <= 1'b1;
        end
        HALTING: if (core_idle) begin
          dpc_q   <= pc;
          halted  <= 1'b1;
          state_q <= HALTED;
        end
        HALTED: if (exec) begin
          data0_q <= data0_in;
          regno_q <= command[11:0];
          idx_q   <= off_d[4:0];
          err_q   <= err_d;
          xfer_q  <= command[17];
          wr_q    <= command[16];
          gpr_q   <= gpr_d;
          dpcr_q  <= dpcr_d;
          state_q <= ACCESS;
        end else if (resume_req && !halt_req) begin
          halted      <= 1'b0;
          core_stall  <= 1'b0;
          core_resume <= 1'b1;
          state_q     <= RESUMING;
        end
        ACCESS: begin
          done      <= 1'b1;
          error     <= err_q;
          exception <= exc;
          write     <= rd_ok;
          if (rd_ok) data0_out <= rdata;
          if (act && dpcr_q && wr_q) dpc_q <= data0_q;
          state_q <= REPORT;
        end
        REPORT:   state_q <= HALTED;
        RESUMING: state_q <= RUNNING;
        default:  state_q <= RUNNING;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_hart_ctrl.sv
// tb_debug_hart_ctrl: directed and randomized abstract commands checked against a field-level reference model
module tb_debug_hart_ctrl;
  logic        clk = 1'b0;
  logic        rst, halt_req, resume_req, exec, core_idle, csr_illegal;
  logic [31:0] command, data0_in, data1_in, pc, gpr_rdata, csr_rdata;
  logic        halted, done, write, error, exception, core_stall, core_resume;
  logic        gpr_we, csr_re, csr_we;
  logic [31:0] data0_out, resume_pc, gpr_wdata, csr_wdata;
  logic [4:0]  gpr_addr;
  logic [11:0] csr_addr;
  int n_cmp = 0, n_err = 0;
  logic [31:0] rf [32];
  logic [31:0] csr_mem [4096];
  logic [31:0] m_gpr [32];
  logic [31:0] m_csr [4096];
  logic [31:0] m_dpc;
  logic        env_init;

  debug_hart_ctrl dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .resume_req(resume_req), .exec(exec),
    .command(command), .data0_in(data0_in), .data1_in(data1_in), .halted(halted),
    .done(done), .write(write), .error(error), .exception(exception), .data0_out(data0_out),
    .core_stall(core_stall), .core_idle(core_idle), .pc(pc), .core_resume(core_resume),
    .resume_pc(resume_pc), .gpr_addr(gpr_addr), .gpr_we(gpr_we), .gpr_wdata(gpr_wdata),
    .gpr_rdata(gpr_rdata), .csr_addr(csr_addr), .csr_re(csr_re), .csr_we(csr_we),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  // Environment: register file (x0 discards writes) and CSR file driven by the DUT's strobes
  assign gpr_rdata = rf[gpr_addr];
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= m_gpr[i];
      for (int i = 0; i < 4096; i++) csr_mem[i] <= m_csr[i];
    end else begin
      if (gpr_we && gpr_addr != 5'd0) rf[gpr_addr] <= gpr_wdata;
      if (csr_we && !csr_illegal) csr_mem[csr_addr] <= csr_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] d0, input logic ill,
                         input logic also_resume, input string tag);
    logic [15:0] regno;
    logic [4:0]  idx;
    logic        is_gpr, is_csr, is_dpc, err, act, wr, ecsr, exc, rd_ok;
    logic [31:0] rd;
    logic [20:0] got_a, exp_a;
    logic [3:0]  got_r, exp_r;
    regno  = cmd[15:0];
    wr     = cmd[16];
    is_gpr = regno >= 16'h1000 && regno <= 16'h101F;
    is_csr = regno < 16'h1000;
    is_dpc = regno == 16'h07B1;
    err    = cmd[31:24] != 8'h00 || cmd[22:20] != 3'd2 || cmd[19] || cmd[18] ||
             (cmd[17] && !is_gpr && !is_csr);
    act    = !err && cmd[17];
    idx    = regno[4:0];
    ecsr   = act && is_csr && !is_dpc;
    exc    = ecsr && ill;
    rd_ok  = act && !wr && !exc;
    rd     = is_gpr ? m_gpr[idx] : is_dpc ? m_dpc : m_csr[regno[11:0]];
    command = cmd; data0_in = d0; exec = 1'b1; resume_req = also_resume; csr_illegal = ill;
    tick;
    exec = 1'b0; resume_req = 1'b0;
    got_a = {gpr_we, gpr_addr, csr_re, csr_we, csr_addr, done};
    exp_a = {act && is_gpr && wr, (act && is_gpr) ? idx : 5'd0, ecsr && !wr, ecsr && wr,
             ecsr ? regno[11:0] : 12'd0, 1'b0};
    n_cmp++;
    if (got_a !== exp_a) begin
      n_err++;
      $display("FAIL %s access strobes {gpr_we,gpr_addr,csr_re,csr_we,csr_addr,done}: got %h want %h", tag, got_a, exp_a);
    end
    if (act && wr && is_gpr) begin
      n_cmp++;
      if (gpr_wdata !== d0) begin
        n_err++;
        $display("FAIL %s gpr_wdata: got %h want %h", tag, gpr_wdata, d0);
      end
    end
    if (ecsr && wr) begin
      n_cmp++;
      if (csr_wdata !== d0) begin
        n_err++;
        $display("FAIL %s csr_wdata: got %h want %h", tag, csr_wdata, d0);
      end
    end
    tick;
    csr_illegal = 1'b0;
    got_r = {done, error, exception, write};
    exp_r = {1'b1, err, exc, rd_ok};
    n_cmp++;
    if (got_r !== exp_r) begin
      n_err++;
      $display("FAIL %s report {done,error,exception,write}: got %b want %b", tag, got_r, exp_r);
    end
    if (rd_ok) begin
      n_cmp++;
      if (data0_out !== rd) begin
        n_err++;
        $display("FAIL %s data0_out: got %h want %h", tag, data0_out, rd);
      end
    end
    if (act && wr) begin
      if (is_gpr) begin
        if (idx != 5'd0) m_gpr[idx] = d0;
      end else if (is_dpc) m_dpc = d0;
      else if (!ill) m_csr[regno[11:0]] = d0;
    end
    tick;
    n_cmp++;
    if ({halted, done, core_resume} !== 3'b100) begin
      n_err++;
      $display("FAIL %s back_to_halted {halted,done,core_resume}: got %b want 100", tag, {halted, done, core_resume});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_gpr[i] = (i == 0) ? 32'd0 : $urandom;
    for (int i = 0; i < 4096; i++) m_csr[i] = $urandom;
    env_init = 1'b1;
    tick;
    env_init = 1'b0;
    tick;
    n_cmp++;
    if ({halted, done, write, error, exception, core_stall, core_resume, gpr_we, csr_re, csr_we} !== 10'd0) begin
      n_err++;
      $display("FAIL reset flags: got %b want 0", {halted, done, write, error, exception, core_stall, core_resume, gpr_we, csr_re, csr_we});
    end
    n_cmp++;
    if ({data0_out, resume_pc, gpr_addr, csr_addr} !== 81'd0) begin
      n_err++;
      $display("FAIL reset data: got %h want 0", {data0_out, resume_pc, gpr_addr, csr_addr});
    end
    rst = 1'b0;
  endtask

  task automatic test_halt;
    halt_req = 1'b1; core_idle = 1'b0; pc = $urandom;
    tick;
    n_cmp++;
    if ({core_stall, halted} !== 2'b10) begin
      n_err++;
      $display("FAIL halting {core_stall,halted}: got %b want 10", {core_stall, halted});
    end
    tick;
    tick;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_err++;
      $display("FAIL halted_before_idle: got %b want 0", halted);
    end
    core_idle = 1'b1; pc = 32'h8000_0040;
    tick;
    core_idle = 1'b0; halt_req = 1'b0; pc = $urandom;
    n_cmp++;
    if ({core_stall, halted} !== 2'b11) begin
      n_err++;
      $display("FAIL halted_rise {core_stall,halted}: got %b want 11", {core_stall, halted});
    end
    m_dpc = 32'h8000_0040;
    run_cmd(32'h0022_07B1, 32'd0, 1'b0, 1'b0, "dpc_read");
  endtask

  task automatic test_gpr;
    run_cmd(32'h0023_1005, 32'hDEAD_BEEF, 1'b0, 1'b0, "gpr_write");
    run_cmd(32'h0022_1005, 32'd0, 1'b0, 1'b0, "gpr_read");
    run_cmd(32'h0023_1000, 32'h1234_5678, 1'b0, 1'b0, "x0_write");
    run_cmd(32'h0022_1000, 32'd0, 1'b0, 1'b0, "x0_read");
    run_cmd(32'h0022_101F, 32'd0, 1'b0, 1'b0, "x31_read");
  endtask

  task automatic test_errors;
    run_cmd(32'h0012_1005, 32'h1, 1'b0, 1'b0, "err_aarsize");
    run_cmd(32'h0126_1005, 32'h2, 1'b0, 1'b0, "err_cmdtype");
    run_cmd(32'h0022_1025, 32'h3, 1'b0, 1'b0, "err_gpr_range");
    run_cmd(32'h0026_1005, 32'h4, 1'b0, 1'b0, "err_postexec");
    run_cmd(32'h002A_1005, 32'h5, 1'b0, 1'b0, "err_postinc");
    run_cmd(32'h0021_1025, 32'h6, 1'b0, 1'b0, "no_transfer");
  endtask

  task automatic test_csr_fault;
    run_cmd(32'h0022_0300, 32'd0, 1'b1, 1'b0, "csr_fault");
    run_cmd(32'h0023_0305, 32'hCAFE_0001, 1'b0, 1'b0, "csr_write");
    run_cmd(32'h0022_0305, 32'd0, 1'b0, 1'b0, "csr_read");
  endtask

  task automatic test_random;
    logic [31:0] c;
    logic [15:0] r;
    int k;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      r = k < 4 ? 16'h1000 + 16'($urandom_range(0, 31)) :
          k < 6 ? 16'h07B1 :
          k < 8 ? 16'($urandom_range(0, 4095)) : 16'($urandom_range(16'h1020, 16'hFFFF));
      c = {8'h00, 1'b0, 3'd2, 2'b00, 1'($urandom_range(0, 9) != 0), 1'($urandom), r};
      k = $urandom_range(0, 15);
      if (k == 0) c[31:24] = 8'($urandom_range(1, 255));
      if (k == 1) c[22:20] = 3'($urandom_range(3, 7));
      if (k == 2) c[19] = 1'b1;
      if (k == 3) c[18] = 1'b1;
      run_cmd(c, $urandom, 1'($urandom_range(0, 3) == 0), 1'b0, "random");
    end
  endtask

  task automatic test_resume;
    run_cmd(32'h0023_07B1, 32'h8000_0100, 1'b0, 1'b0, "dpc_write");
    halt_req = 1'b1; resume_req = 1'b1;
    tick;
    resume_req = 1'b0;
    tick;
    n_cmp++;
    if ({halted, core_resume, core_stall} !== 3'b101) begin
      n_err++;
      $display("FAIL resume_blocked {halted,core_resume,core_stall}: got %b want 101", {halted, core_resume, core_stall});
    end
    halt_req = 1'b0;
    run_cmd(32'h0022_1005, 32'd0, 1'b0, 1'b1, "exec_over_resume");
    resume_req = 1'b1;
    tick;
    resume_req = 1'b0;
    n_cmp++;
    if ({core_resume, halted, core_stall} !== 3'b100 || resume_pc !== 32'h8000_0100) begin
      n_err++;
      $display("FAIL resuming {core_resume,halted,core_stall}/resume_pc: got %b/%h want 100/80000100", {core_resume, halted, core_stall}, resume_pc);
    end
    tick;
    n_cmp++;
    if ({core_resume, halted, core_stall} !== 3'b000) begin
      n_err++;
      $display("FAIL running {core_resume,halted,core_stall}: got %b want 000", {core_resume, halted, core_stall});
    end
    command = 32'h0023_1007; data0_in = 32'h5555_AAAA; exec = 1'b1;
    tick;
    exec = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({done, gpr_we} !== 2'b00) begin
        n_err++;
        $display("FAIL exec_while_running {done,gpr_we}: got %b want 00", {done, gpr_we});
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    halt_req = 1'b1; core_idle = 1'b1; pc = 32'h8000_0200;
    tick;
    tick;
    halt_req = 1'b0; core_idle = 1'b0;
    command = 32'h0023_1008; data0_in = $urandom; exec = 1'b1;
    tick;
    exec = 1'b0;
    n_cmp++;
    if ({halted, gpr_we, gpr_addr} !== {1'b1, 1'b1, 5'd8}) begin
      n_err++;
      $display("FAIL mid_access {halted,gpr_we,gpr_addr}: got %b want 1101000", {halted, gpr_we, gpr_addr});
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if ({done, halted, core_stall} !== 3'b000 || resume_pc !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid {done,halted,core_stall}/dpc: got %b/%h want 000/0", {done, halted, core_stall}, resume_pc);
    end
    tick;
    n_cmp++;
    if ({done, halted, core_stall} !== 3'b000) begin
      n_err++;
      $display("FAIL after_reset_mid {done,halted,core_stall}: got %b want 000", {done, halted, core_stall});
    end
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; resume_req = 1'b0; exec = 1'b0; core_idle = 1'b0;
    csr_illegal = 1'b0; command = 32'd0; data0_in = 32'd0; data1_in = 32'hA5A5_5A5A;
    pc = 32'd0; m_dpc = 32'd0; env_init = 1'b0;
    #1;
    test_reset;
    test_halt;
    test_gpr;
    test_errors;
    test_csr_fault;
    test_random;
    test_resume;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
